// File: rtl/optic_flow_encoder_ci.sv
// optic_flow_encoder_ci
//   Multi-cycle custom instruction that turns 4 current and 4 previous-frame
//   grayscale pixels into 4 packed optic-flow nibble codes {mag[1:0],dir[1:0]}.
//   A companion control CI (customInstructionId+1) does row start and threshold load.
//   Optional feature macro: OPTIC_FLOW_THRESH_CFG_EN (runtime threshold load).
//   Without it the threshold is fixed at DEFAULT_THRESH.
// Ports
//   clock   in   system clock
//   nReset  in   asynchronous active-low reset
//   start   in   CI start strobe, qualified by ciN
//   ciN     in   [7:0]  CI number
//   valueA  in   [31:0] encode: current pixels p0..p3 (byte i = pixel i); control: command
//   valueB  in   [31:0] encode: previous-frame pixels; control: [7:0] new threshold
//   done    out  single-cycle completion pulse
//   result  out  [31:0] result word, forced to 0 while done is low
module optic_flow_encoder_ci #(
  parameter logic [7:0] customInstructionId = 8'd31,
  parameter logic [7:0] DEFAULT_THRESH      = 8'd8
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [7:0] CTRL_ID = customInstructionId + 8'd1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] prev_q, prev_d;
  logic [7:0]  carry_q, carry_d;
  logic        carry_vld_q, carry_vld_d;
  logic [15:0] pack_q, pack_d;
  logic [15:0] new_q, new_d;
  logic [31:0] res_q, res_d;

  logic [7:0]  thr;       // threshold in use
  logic [7:0]  ctrl_thr;  // threshold after a control call would apply

`ifdef OPTIC_FLOW_THRESH_CFG_EN
  logic [7:0] thr_q, thr_d;
  assign thr = thr_q;

  // A zero threshold would flag every still pixel as motion; clamp to 1.
  always_comb begin
    ctrl_thr = thr_q;
    if (valueA[1])
      ctrl_thr = (valueB[7:0] == 8'd0) ? 8'd1 : valueB[7:0];
  end
`else
  assign thr      = DEFAULT_THRESH;
  assign ctrl_thr = DEFAULT_THRESH;
`endif

  // ---------------------------------------------------------------------------
  // Per-pixel datapath for pixel idx_q
  // ---------------------------------------------------------------------------
  logic [7:0] px_cur, px_prev, px_left, px_right;
  logic [8:0] it, ix;
  logic [8:0] it_abs, ix_abs;
  logic [9:0] t1, t2, t4;
  logic [1:0] dir, mag;
  logic [3:0] code;
  logic [15:0] new_nib;

  always_comb begin
    px_cur  = cur_q[idx_q*8 +: 8];
    px_prev = prev_q[idx_q*8 +: 8];
    // Left neighbour of pixel 0 comes from the previous call on the same row.
    if (idx_q == 2'd0)
      px_left = carry_vld_q ? carry_q : cur_q[7:0];
    else
      px_left = cur_q[(idx_q-2'd1)*8 +: 8];
    // Right neighbour of pixel 3 is not known yet; use a one-sided edge.
    if (idx_q == 2'd3)
      px_right = cur_q[31:24];
    else
      px_right = cur_q[(idx_q+2'd1)*8 +: 8];
  end

  assign it     = {1'b0, px_cur}   - {1'b0, px_prev};
  assign ix     = {1'b0, px_right} - {1'b0, px_left};
  assign it_abs = it[8] ? (9'd0 - it) : it;
  assign ix_abs = ix[8] ? (9'd0 - ix) : ix;

  assign t1 = {2'b00, thr};
  assign t2 = {1'b0, thr, 1'b0};
  assign t4 = {thr, 2'b00};

  always_comb begin
    if (({1'b0, it_abs} < t1) || ({1'b0, ix_abs} < t1))
      dir = 2'b00;
    else if (it[8] ^ ix[8])
      dir = 2'b01;
    else
      dir = 2'b10;

    if (dir == 2'b00)               mag = 2'b00;
    else if ({1'b0, it_abs} < t2)   mag = 2'b01;
    else if ({1'b0, it_abs} < t4)   mag = 2'b10;
    else                            mag = 2'b11;
  end

  assign code = {mag, dir};

  always_comb begin
    new_nib = new_q;
    new_nib[idx_q*4 +: 4] = code;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    carry_d     = carry_q;
    carry_vld_d = carry_vld_q;
    pack_d      = pack_q;
    new_d       = new_q;
    res_d       = res_q;
`ifdef OPTIC_FLOW_THRESH_CFG_EN
    thr_d       = thr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && ciN == customInstructionId) begin
          cur_d   = valueA;
          prev_d  = valueB;
          idx_d   = 2'd0;
          new_d   = 16'd0;
          state_d = S_COMPUTE;
        end else if (start && ciN == CTRL_ID) begin
          if (valueA[0]) begin
            carry_vld_d = 1'b0;
            pack_d      = 16'd0;
          end
`ifdef OPTIC_FLOW_THRESH_CFG_EN
          thr_d = ctrl_thr;
`endif
          res_d   = {24'd0, ctrl_thr};
          state_d = S_DONE;
        end
      end
      S_COMPUTE: begin
        new_d = new_nib;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          // Older word in the upper half so two calls hold 8 pixels in order.
          res_d       = {pack_q, new_nib};
          pack_d      = new_nib;
          carry_d     = cur_q[31:24];
          carry_vld_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      cur_q       <= 32'd0;
      prev_q      <= 32'd0;
      carry_q     <= 8'd0;
      carry_vld_q <= 1'b0;
      pack_q      <= 16'd0;
      new_q       <= 16'd0;
      res_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      carry_q     <= carry_d;
      carry_vld_q <= carry_vld_d;
      pack_q      <= pack_d;
      new_q       <= new_d;
      res_q       <= res_d;
    end
  end

`ifdef OPTIC_FLOW_THRESH_CFG_EN
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) thr_q <= DEFAULT_THRESH;
    else         thr_q <= thr_d;
  end
`endif

  assign done   = (state_q == S_DONE);
  assign result = done ? res_q : 32'd0;

endmodule

// File: tb/tb_optic_flow_encoder_ci.sv
module tb_optic_flow_encoder_ci;

  localparam logic [7:0] ID   = 8'd31;
  localparam logic [7:0] CTRL = 8'd32;

  logic        clock;
  logic        nReset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB;
  logic        done;
  logic [31:0] result;

  optic_flow_encoder_ci #(.customInstructionId(ID), .DEFAULT_THRESH(8'd8)) dut (
    .clock(clock), .nReset(nReset), .start(start), .ciN(ciN),
    .valueA(valueA), .valueB(valueB), .done(done), .result(result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard
  typedef struct {
    logic [31:0] res;
    int          t0;
    int          lat;
    string       tag;
  } exp_t;
  exp_t sb[$];

  always @(negedge clock) begin
    if (nReset && done) begin
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_res"}, result, e.res);
        chk({e.tag, "_lat"}, cyc - e.t0, e.lat);
      end else begin
        chk("unexp_done", 32'(done), 32'd0);
      end
    end
  end

  // reference model
  int          m_t;
  logic [7:0]  m_carry;
  bit          m_cv;
  logic [15:0] m_pack;

  task automatic m_reset();
    m_t = 8; m_carry = 8'd0; m_cv = 1'b0; m_pack = 16'd0;
  endtask

  function automatic logic [15:0] m_encode(input logic [31:0] a, input logic [31:0] b);
    int c[-1:4];
    int p[4];
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < 4; i++) begin
      c[i] = int'(a[8*i +: 8]);
      p[i] = int'(b[8*i +: 8]);
    end
    c[-1] = m_cv ? int'(m_carry) : c[0];
    c[4]  = c[3];
    for (int i = 0; i < 4; i++) begin
      int dt, dx, at, ax;
      logic [1:0] d, m;
      dt = c[i] - p[i];
      dx = c[i+1] - c[i-1];
      at = (dt < 0) ? -dt : dt;
      ax = (dx < 0) ? -dx : dx;
      if (at < m_t || ax < m_t)       d = 2'b00;
      else if ((dt < 0) != (dx < 0))  d = 2'b01;
      else                            d = 2'b10;
      if (d == 2'b00)         m = 2'b00;
      else if (at < 2*m_t)    m = 2'b01;
      else if (at < 4*m_t)    m = 2'b10;
      else                    m = 2'b11;
      r[4*i +: 4] = {m, d};
    end
    return r;
  endfunction

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      chk({tag, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  // encode call; glitch=1 keeps start high with junk during COMPUTE
  task automatic encode(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit glitch = 1'b0);
    logic [15:0] n;
    exp_t e;
    n = m_encode(a, b);
    @(posedge clock); #1;
    start = 1'b1; ciN = ID; valueA = a; valueB = b;
    e.res = {m_pack, n}; e.t0 = cyc; e.lat = 5; e.tag = tag;
    sb.push_back(e);
    m_pack = n; m_carry = a[31:24]; m_cv = 1'b1;
    @(posedge clock); #1;
    if (glitch) begin
      ciN = CTRL; valueA = 32'h3; valueB = 32'h0;
      repeat (2) @(posedge clock);
      #1; ciN = ID; valueA = 32'hFFFF_FFFF; valueB = 32'h0;
      @(posedge clock); #1;
    end
    start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
    wait_idle(tag);
  endtask

  task automatic control(input string tag, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (a[0]) begin m_cv = 1'b0; m_pack = 16'd0; end
`ifdef OPTIC_FLOW_THRESH_CFG_EN
    if (a[1]) m_t = (b[7:0] == 8'd0) ? 1 : int'(b[7:0]);
`endif
    @(posedge clock); #1;
    start = 1'b1; ciN = CTRL; valueA = a; valueB = b;
    e.res = 32'(m_t); e.t0 = cyc; e.lat = 1; e.tag = tag;
    sb.push_back(e);
    @(posedge clock); #1;
    start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
    wait_idle(tag);
  endtask

  initial begin
    nReset = 1'b0; start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;
    m_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    nReset = 1'b1;

    // unrelated CI number is ignored
    @(posedge clock); #1;
    start = 1'b1; ciN = 8'd47; valueA = 32'h40302010; valueB = 32'h30201000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_result", result, 32'd0);
    end
    @(posedge clock); #1;
    start = 1'b0; ciN = 8'd0; valueA = 32'd0; valueB = 32'd0;

    control("row0", 32'h1, 32'h0);
    encode("flat0", 32'h40302010, 32'h40302010);

    control("row1", 32'h1, 32'h0);
    encode("right_mv", 32'h40302010, 32'h30201000);
    encode("flat1", 32'h40302010, 32'h40302010);

    control("row2", 32'h1, 32'h0);
    encode("left_mv", 32'h10203040, 32'h00102030);

    // threshold load (feature-dependent expectations come from the model)
    control("thr32", 32'h2, 32'd32);
    control("row3", 32'h1, 32'h0);
    encode("thr_enc", 32'h40302010, 32'h30201000);
    control("thr0", 32'h2, 32'd0);
    control("thr8", 32'h3, 32'd8);

    // large motion exercises mag=11 and carry across calls; ignored restarts mid-call
    encode("big", 32'hF0C08040, 32'h20100000);
    encode("carry", 32'h10203040, 32'h90A0B0C0, 1'b1);
    for (int k = 0; k < 6; k++)
      encode("rand", $urandom, $urandom, k[0]);

    // reset in the middle of an encode: no done, state back to reset values
    @(posedge clock); #1;
    start = 1'b1; ciN = ID; valueA = 32'h40302010; valueB = 32'h30201000;
    @(posedge clock); #1;
    start = 1'b0; ciN = 8'd0;
    @(posedge clock); #1;
    nReset = 1'b0;
    m_reset();
    @(negedge clock);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    @(posedge clock); #1;
    nReset = 1'b1;
    repeat (8) @(negedge clock);
    encode("post_rst", 32'h40302010, 32'h30201000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
